// File: rtl/amdc_eddy_current_sequencer_if.sv
// Start/done handshake and result bus between the sample sequencer and the eddy current SPI master.
interface amdc_eddy_current_sequencer_if #(
  parameter int DATA_W = 18
);
  logic              spi_start;
  logic              spi_done;
  logic [DATA_W-1:0] spi_data_x;
  logic [DATA_W-1:0] spi_data_y;

  modport master (
    output spi_start,
    input  spi_done,
    input  spi_data_x,
    input  spi_data_y
  );

  modport slave (
    input  spi_start,
    output spi_done,
    output spi_data_x,
    output spi_data_y
  );
endinterface

// File: rtl/amdc_eddy_current_sequencer.sv
// Turns PWM carrier triggers into decimated SPI start pulses, waits for done with a timeout,
// and latches X/Y results with valid strobe, sample counter and sticky error status.
module amdc_eddy_current_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [1:0]                    trig_sel,
  input  logic                          trig_high,
  input  logic                          trig_low,
  input  logic [7:0]                    decim,
  input  logic [CNT_W-1:0]              timeout_cycles,
  input  logic                          clr_status,
  amdc_eddy_current_sequencer_if.master spi,
  output logic [17:0]                   data_x,
  output logic [17:0]                   data_y,
  output logic                          data_valid,
  output logic [CNT_W-1:0]              sample_cnt,
  output logic                          busy,
  output logic                          timeout_err,
  output logic [7:0]                    overrun_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t           state;
  logic [7:0]       dcnt;
  logic [CNT_W-1:0] tcnt;
  logic             spi_done_d;

  logic trig_acc;
  logic done_edge;
  logic timeout_hit;
  logic overrun_ev;
  logic timeout_ev;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign trig_acc    = enable & ((trig_sel[0] & trig_high) | (trig_sel[1] & trig_low));
  // done stays high from the previous frame, so only a fresh rising edge means new data
  assign done_edge   = spi.spi_done & ~spi_done_d;
  assign timeout_hit = (timeout_cycles != '0) && (tcnt == timeout_cycles);
  assign overrun_ev  = trig_acc && (state != IDLE);
  assign timeout_ev  = (state == WAIT) && !done_edge && timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      dcnt          <= '0;
      tcnt          <= '0;
      spi_done_d    <= 1'b0;
      spi.spi_start <= 1'b0;
      data_x        <= '0;
      data_y        <= '0;
      data_valid    <= 1'b0;
      sample_cnt    <= '0;
      busy          <= 1'b0;
    end else begin
      spi_done_d    <= spi.spi_done;
      spi.spi_start <= 1'b0;
      data_valid    <= 1'b0;
      case (state)
        IDLE: begin
          if (!enable) begin
            dcnt <= '0;
          end else if (trig_acc) begin
            // >= rather than == so lowering decim mid-count cannot strand dcnt above it
            if (dcnt >= decim) begin
              dcnt          <= '0;
              state         <= START;
              spi.spi_start <= 1'b1;
              busy          <= 1'b1;
            end else begin
              dcnt <= dcnt + 8'd1;
            end
          end
        end
        START: begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          tcnt <= tcnt + CNT_W'(1);
          if (done_edge) begin
            data_x     <= spi.spi_data_x;
            data_y     <= spi.spi_data_y;
            data_valid <= 1'b1;
            sample_cnt <= sample_cnt + CNT_W'(1);
            state      <= LATCH;
          end else if (timeout_hit) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        LATCH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Status: a set/increment in the same cycle as clr_status takes precedence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      if (timeout_ev) begin
        timeout_err <= 1'b1;
      end else if (clr_status) begin
        timeout_err <= 1'b0;
      end
      if (overrun_ev) begin
        overrun_cnt <= clr_status ? 8'd1 : sat_inc8(overrun_cnt);
      end else if (clr_status) begin
        overrun_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_amdc_eddy_current_sequencer.sv
// Bench for the eddy current sample sequencer: SPI master model plus scenario tasks with a trigger-count model.
`timescale 1ns/1ps
module tb_amdc_eddy_current_sequencer;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic [1:0]       trig_sel = 2'b00;
  logic             trig_high = 1'b0;
  logic             trig_low = 1'b0;
  logic [7:0]       decim = 8'd0;
  logic [CNT_W-1:0] timeout_cycles = '0;
  logic             clr_status = 1'b0;
  logic [17:0]      data_x, data_y;
  logic             data_valid;
  logic [CNT_W-1:0] sample_cnt;
  logic             busy, timeout_err;
  logic [7:0]       overrun_cnt;

  amdc_eddy_current_sequencer_if sif ();

  amdc_eddy_current_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .trig_sel(trig_sel),
    .trig_high(trig_high), .trig_low(trig_low), .decim(decim),
    .timeout_cycles(timeout_cycles), .clr_status(clr_status), .spi(sif),
    .data_x(data_x), .data_y(data_y), .data_valid(data_valid),
    .sample_cnt(sample_cnt), .busy(busy), .timeout_err(timeout_err),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // SPI master model: clears done on start (or hold cycles later), raises done with data after lat cycles
  int          spi_lat = 10;
  int          spi_hold = 0;
  int          spi_age = 0;
  bit          spi_never = 1'b0;
  bit          spi_active = 1'b0;
  logic [17:0] spi_nx = '0;
  logic [17:0] spi_ny = '0;
  int          start_cnt = 0;
  int          valid_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      spi_active     = 1'b0;
      sif.spi_done   = 1'b0;
      sif.spi_data_x = '0;
      sif.spi_data_y = '0;
    end else if (sif.spi_start) begin
      start_cnt++;
      spi_age    = 0;
      spi_active = 1'b1;
      if (spi_hold == 0) sif.spi_done = 1'b0;
    end else if (spi_active) begin
      spi_age++;
      if (spi_age == spi_hold) sif.spi_done = 1'b0;
      if (!spi_never && spi_age == spi_lat) begin
        sif.spi_done   = 1'b1;
        sif.spi_data_x = spi_nx;
        sif.spi_data_y = spi_ny;
        spi_active     = 1'b0;
      end
    end
    if (data_valid) valid_cnt++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input bit h, input bit l);
    trig_high = h;
    trig_low  = l;
    tick(1);
    trig_high = 1'b0;
    trig_low  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    vecs++; if ({sif.spi_start, data_valid, busy, timeout_err} !== 4'b0) begin errs++; $display("FAIL reset_flags got=%b exp=0000", {sif.spi_start, data_valid, busy, timeout_err}); end
    vecs++; if ({data_x, data_y} !== 36'd0) begin errs++; $display("FAIL reset_data got=%h exp=0", {data_x, data_y}); end
    vecs++; if (sample_cnt !== '0) begin errs++; $display("FAIL reset_sample_cnt got=%0d exp=0", sample_cnt); end
    vecs++; if (overrun_cnt !== 8'd0) begin errs++; $display("FAIL reset_overrun got=%0d exp=0", overrun_cnt); end
    rst_n = 1'b1;
    tick(2);
    vecs++; if ({sif.spi_start, busy} !== 2'b00) begin errs++; $display("FAIL reset_release got=%b exp=00", {sif.spi_start, busy}); end
  endtask

  task automatic test_single_frame();
    int n;
    enable = 1'b1; trig_sel = 2'b01; decim = 8'd0; timeout_cycles = '0;
    spi_lat = 300; spi_hold = 0; spi_never = 1'b0;
    spi_nx = 18'h2AAAA; spi_ny = 18'h15555;
    pulse(1'b0, 1'b1);
    vecs++; if (sif.spi_start !== 1'b0) begin errs++; $display("FAIL low_not_selected got=%b exp=0", sif.spi_start); end
    tick(2);
    pulse(1'b1, 1'b0);
    vecs++; if (sif.spi_start !== 1'b1) begin errs++; $display("FAIL start_pulse got=%b exp=1", sif.spi_start); end
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL busy_rise got=%b exp=1", busy); end
    tick(1);
    vecs++; if (sif.spi_start !== 1'b0) begin errs++; $display("FAIL start_width got=%b exp=0", sif.spi_start); end
    n = 1;
    while (data_valid !== 1'b1 && n < 1000) begin tick(1); n++; end
    vecs++; if (n !== 301) begin errs++; $display("FAIL valid_latency got=%0d exp=301", n); end
    vecs++; if ({data_x, data_y} !== {18'h2AAAA, 18'h15555}) begin errs++; $display("FAIL single_data got=%h/%h exp=2aaaa/15555", data_x, data_y); end
    vecs++; if (sample_cnt !== CNT_W'(1)) begin errs++; $display("FAIL single_cnt got=%0d exp=1", sample_cnt); end
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL busy_latch got=%b exp=1", busy); end
    tick(1);
    vecs++; if ({data_valid, busy} !== 2'b00) begin errs++; $display("FAIL valid_width_busy_fall got=%b exp=00", {data_valid, busy}); end
  endtask

  task automatic test_decim_plan();
    bit [1:0] ev [8] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    int acc = 0;
    int s0;
    enable = 1'b0; tick(1); enable = 1'b1;
    trig_sel = 2'b11; decim = 8'd3; spi_lat = 20;
    s0 = start_cnt;
    for (int i = 0; i < 8; i++) begin
      spi_nx = 18'($urandom); spi_ny = 18'($urandom);
      pulse(ev[i][0], ev[i][1]);
      acc++;
      vecs++; if (sif.spi_start !== ((acc % 4) == 0)) begin errs++; $display("FAIL decim_plan trig%0d got=%b exp=%b", i, sif.spi_start, ((acc % 4) == 0)); end
      tick(60);
    end
    vecs++; if (start_cnt - s0 !== 2) begin errs++; $display("FAIL decim_plan_starts got=%0d exp=2", start_cnt - s0); end
  endtask

  task automatic test_decim_random();
    for (int r = 0; r < 3; r++) begin
      bit [1:0]         sel;
      int               d, acc, fires;
      bit               h, l, fire;
      logic [17:0]      ex, ey, nx, ny;
      logic [CNT_W-1:0] exp_cnt;
      sel = 2'($urandom_range(1, 3));
      d   = $urandom_range(0, 3);
      enable = 1'b0; tick(1); enable = 1'b1;
      trig_sel = sel; decim = 8'(d); spi_lat = $urandom_range(5, 40);
      acc = 0; fires = 0; ex = data_x; ey = data_y; exp_cnt = sample_cnt;
      for (int i = 0; i < 10; i++) begin
        h = 1'($urandom); l = 1'($urandom);
        nx = 18'($urandom); ny = 18'($urandom);
        spi_nx = nx; spi_ny = ny;
        fire = 1'b0;
        if ((sel[0] & h) | (sel[1] & l)) begin
          acc++;
          fire = ((acc % (d + 1)) == 0);
        end
        pulse(h, l);
        vecs++; if (sif.spi_start !== fire) begin errs++; $display("FAIL decim_rand r%0d e%0d got=%b exp=%b", r, i, sif.spi_start, fire); end
        if (fire) begin fires++; ex = nx; ey = ny; exp_cnt = exp_cnt + CNT_W'(1); end
        tick(50);
      end
      vecs++; if (sample_cnt !== exp_cnt) begin errs++; $display("FAIL decim_rand_cnt r%0d got=%0d exp=%0d", r, sample_cnt, exp_cnt); end
      vecs++; if ({data_x, data_y} !== {ex, ey}) begin errs++; $display("FAIL decim_rand_data r%0d got=%h/%h exp=%h/%h", r, data_x, data_y, ex, ey); end
    end
  endtask

  task automatic test_overrun();
    int n, s0;
    logic [CNT_W-1:0] c0;
    enable = 1'b1; trig_sel = 2'b01; decim = 8'd0; timeout_cycles = '0;
    spi_lat = 500; spi_never = 1'b0; spi_hold = 0;
    s0 = start_cnt; c0 = sample_cnt;
    pulse(1'b1, 1'b0);
    tick(9);  pulse(1'b1, 1'b0);
    tick(89); pulse(1'b1, 1'b0);
    vecs++; if (overrun_cnt !== 8'd2) begin errs++; $display("FAIL overrun_two got=%0d exp=2", overrun_cnt); end
    enable = 1'b0;
    pulse(1'b1, 1'b1);
    vecs++; if (overrun_cnt !== 8'd2) begin errs++; $display("FAIL overrun_disabled got=%0d exp=2", overrun_cnt); end
    n = 0;
    while (data_valid !== 1'b1 && n < 1000) begin tick(1); n++; end
    vecs++; if (sample_cnt !== c0 + CNT_W'(1)) begin errs++; $display("FAIL overrun_frame_cnt got=%0d exp=%0d", sample_cnt, c0 + CNT_W'(1)); end
    vecs++; if (start_cnt - s0 !== 1) begin errs++; $display("FAIL overrun_starts got=%0d exp=1", start_cnt - s0); end
    vecs++; if (timeout_err !== 1'b0) begin errs++; $display("FAIL timeout_disabled got=%b exp=0", timeout_err); end
    enable = 1'b1;
    tick(2);
    clr_status = 1'b1; tick(1); clr_status = 1'b0;
    vecs++; if (overrun_cnt !== 8'd0) begin errs++; $display("FAIL overrun_clear got=%0d exp=0", overrun_cnt); end
  endtask

  task automatic test_overrun_saturate();
    int n;
    enable = 1'b1; trig_sel = 2'b01; decim = 8'd0; spi_lat = 800;
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 260; i++) begin pulse(1'b1, 1'b0); tick(1); end
    vecs++; if (overrun_cnt !== 8'd255) begin errs++; $display("FAIL overrun_sat got=%0d exp=255", overrun_cnt); end
    clr_status = 1'b1; trig_high = 1'b1;
    tick(1);
    clr_status = 1'b0; trig_high = 1'b0;
    vecs++; if (overrun_cnt !== 8'd1) begin errs++; $display("FAIL overrun_clr_collide got=%0d exp=1", overrun_cnt); end
    n = 0;
    while (busy !== 1'b0 && n < 1000) begin tick(1); n++; end
    vecs++; if (n >= 1000) begin errs++; $display("FAIL sat_frame_end got=%0d exp<1000", n); end
    clr_status = 1'b1; tick(1); clr_status = 1'b0;
  endtask

  task automatic test_timeout();
    int tv [2];
    int n, v0;
    logic [17:0] ox, nx;
    logic [CNT_W-1:0] c0;
    tv[0] = 50; tv[1] = $urandom_range(1, 40);
    enable = 1'b1; trig_sel = 2'b01; decim = 8'd0; spi_hold = 0;
    for (int k = 0; k < 2; k++) begin
      timeout_cycles = CNT_W'(tv[k]); spi_never = 1'b1;
      ox = data_x; c0 = sample_cnt; v0 = valid_cnt;
      pulse(1'b1, 1'b0);
      n = 0;
      while (timeout_err !== 1'b1 && n < 1000) begin tick(1); n++; end
      vecs++; if (n !== tv[k] + 2) begin errs++; $display("FAIL timeout_latency n=%0d got=%0d exp=%0d", tv[k], n, tv[k] + 2); end
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL timeout_idle got=%b exp=0", busy); end
      vecs++; if (data_x !== ox || sample_cnt !== c0 || valid_cnt !== v0) begin errs++; $display("FAIL timeout_nodata got=%h/%0d/%0d exp=%h/%0d/%0d", data_x, sample_cnt, valid_cnt, ox, c0, v0); end
      timeout_cycles = '0; spi_never = 1'b0; spi_lat = 15;
      nx = 18'($urandom); spi_nx = nx;
      pulse(1'b1, 1'b0);
      vecs++; if (sif.spi_start !== 1'b1) begin errs++; $display("FAIL timeout_restart got=%b exp=1", sif.spi_start); end
      n = 0;
      while (data_valid !== 1'b1 && n < 1000) begin tick(1); n++; end
      vecs++; if (data_x !== nx || timeout_err !== 1'b1) begin errs++; $display("FAIL timeout_recover got=%h/%b exp=%h/1", data_x, timeout_err, nx); end
      tick(2);
      clr_status = 1'b1; tick(1); clr_status = 1'b0;
      vecs++; if (timeout_err !== 1'b0) begin errs++; $display("FAIL timeout_clear got=%b exp=0", timeout_err); end
    end
    timeout_cycles = CNT_W'(20); spi_never = 1'b1;
    pulse(1'b1, 1'b0);
    tick(21);
    clr_status = 1'b1; tick(1); clr_status = 1'b0;
    vecs++; if (timeout_err !== 1'b1) begin errs++; $display("FAIL timeout_clr_collide got=%b exp=1", timeout_err); end
    clr_status = 1'b1; tick(1); clr_status = 1'b0;
    timeout_cycles = '0; spi_never = 1'b0;
  endtask

  task automatic test_done_held();
    int n, lat;
    logic [17:0] nx, ny;
    enable = 1'b1; trig_sel = 2'b01; decim = 8'd0; timeout_cycles = '0;
    for (int k = 0; k < 2; k++) begin
      spi_hold = 0; spi_lat = 10;
      pulse(1'b1, 1'b0);
      tick(20);
      spi_hold = $urandom_range(2, 30);
      lat = spi_hold + $urandom_range(5, 30);
      spi_lat = lat;
      nx = 18'($urandom); ny = 18'($urandom);
      spi_nx = nx; spi_ny = ny;
      pulse(1'b1, 1'b0);
      n = 0;
      while (data_valid !== 1'b1 && n < 1000) begin tick(1); n++; end
      vecs++; if (n !== lat + 1) begin errs++; $display("FAIL held_done_latency got=%0d exp=%0d", n, lat + 1); end
      vecs++; if ({data_x, data_y} !== {nx, ny}) begin errs++; $display("FAIL held_done_data got=%h/%h exp=%h/%h", data_x, data_y, nx, ny); end
      tick(3);
    end
    spi_hold = 0;
  endtask

  task automatic test_reset_midframe();
    int n;
    logic [17:0] nx, ny;
    enable = 1'b1; trig_sel = 2'b01; decim = 8'd0; timeout_cycles = '0; spi_lat = 300;
    pulse(1'b1, 1'b0);
    tick(50);
    rst_n = 1'b0;
    #1;
    vecs++; if ({sif.spi_start, busy, data_valid, timeout_err, overrun_cnt} !== 12'd0) begin errs++; $display("FAIL midreset_flags got=%h exp=0", {sif.spi_start, busy, data_valid, timeout_err, overrun_cnt}); end
    vecs++; if ({data_x, data_y, sample_cnt} !== '0) begin errs++; $display("FAIL midreset_data got=%h/%h/%0d exp=0", data_x, data_y, sample_cnt); end
    tick(3);
    rst_n = 1'b1;
    tick(2);
    vecs++; if ({sif.spi_start, busy} !== 2'b00) begin errs++; $display("FAIL midreset_idle got=%b exp=00", {sif.spi_start, busy}); end
    spi_lat = 40;
    nx = 18'($urandom); ny = 18'($urandom);
    spi_nx = nx; spi_ny = ny;
    pulse(1'b1, 1'b0);
    vecs++; if (sif.spi_start !== 1'b1) begin errs++; $display("FAIL midreset_start got=%b exp=1", sif.spi_start); end
    n = 0;
    while (data_valid !== 1'b1 && n < 1000) begin tick(1); n++; end
    vecs++; if (n !== 41) begin errs++; $display("FAIL midreset_latency got=%0d exp=41", n); end
    vecs++; if ({data_x, data_y} !== {nx, ny} || sample_cnt !== CNT_W'(1)) begin errs++; $display("FAIL midreset_frame got=%h/%h/%0d exp=%h/%h/1", data_x, data_y, sample_cnt, nx, ny); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_decim_plan();
    test_decim_random();
    test_overrun();
    test_overrun_saturate();
    test_timeout();
    test_done_held();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
